// File: rtl/puf_eval_ctrl.sv
// rtl/puf_eval_ctrl.sv - PUF evaluation sequencer with per-bit majority vote
//
// Runs N_EVAL evaluations of a PUF array for one latched challenge/operand
// set. Each evaluation is:
//   CLEAR  (RST_CYCLES)
//   ARM    (2)
//   FIRE   (SETTLE_CYCLES)
//   SAMPLE (1)
// Every response bit is then majority-voted, and any bit whose votes
// disagreed is flagged.
//
// Ports:
//   clk           clock, rising edge
//   reset         asynchronous active-low reset
//   start         measurement request, honoured only in IDLE
//   abort         cancels a measurement in progress
//   challenge_in  challenge to latch on accept
//   a_in, b_in    operand words to latch on accept
//   CHALLENGE     latched challenge driven to the PUF array
//   a, b          latched operand words driven to the PUF array
//   trigger       PUF launch strobe
//   puf_reset     active-high reset to the PUF arbiters
//   RESPONSE      raw PUF array response
//   busy          high whenever not IDLE
//   done          one-cycle pulse on measurement completion
//   response_out  majority-voted response
//   unstable      per-bit flag: votes were not unanimous
module puf_eval_ctrl #(
  parameter int RST_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int N_EVAL        = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [127:0] challenge_in,
  input  logic [15:0]  a_in,
  input  logic [15:0]  b_in,
  output logic [127:0] CHALLENGE,
  output logic [15:0]  a,
  output logic [15:0]  b,
  output logic         trigger,
  output logic         puf_reset,
  input  logic [15:0]  RESPONSE,
  output logic         busy,
  output logic         done,
  output logic [15:0]  response_out,
  output logic [15:0]  unstable
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ARM,
    S_FIRE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [7:0] RST_LAST    = 8'(RST_CYCLES - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] NEV         = 4'(N_EVAL);
  localparam logic [3:0] HALF        = 4'(N_EVAL / 2);

  state_t           state;
  logic [7:0]       phase_cnt;
  logic [3:0]       eval_cnt;
  logic [15:0][3:0] votes;

  // Vote totals including the sample being taken this cycle.
  // This lets the final vote and the DONE outputs be produced on the
  // same edge.
  logic [15:0][3:0] votes_nxt;
  logic [15:0]      maj_nxt;
  logic [15:0]      unst_nxt;

  always_comb begin
    votes_nxt = votes;
    maj_nxt   = '0;
    unst_nxt  = '0;
    for (int i = 0; i < 16; i++) begin
      votes_nxt[i] = votes[i] + {3'b000, RESPONSE[i]};
      maj_nxt[i]   = (votes_nxt[i] > HALF);
      unst_nxt[i]  = (votes_nxt[i] != 4'd0) && (votes_nxt[i] != NEV);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      phase_cnt    <= '0;
      eval_cnt     <= '0;
      votes        <= '0;
      CHALLENGE    <= '0;
      a            <= '0;
      b            <= '0;
      trigger      <= 1'b0;
      puf_reset    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      response_out <= '0;
      unstable     <= '0;
    end else begin
      done <= 1'b0;
      if (abort && state != S_IDLE) begin
        // Abort wins over every transition.
        // Partial votes are simply abandoned; the next accept clears them.
        state     <= S_IDLE;
        phase_cnt <= '0;
        trigger   <= 1'b0;
        puf_reset <= 1'b1;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            trigger   <= 1'b0;
            puf_reset <= 1'b1;
            if (start) begin
              CHALLENGE <= challenge_in;
              a         <= a_in;
              b         <= b_in;
              votes     <= '0;
              eval_cnt  <= '0;
              phase_cnt <= '0;
              busy      <= 1'b1;
              state     <= S_CLEAR;
            end
          end

          S_CLEAR: begin
            if (phase_cnt == RST_LAST) begin
              phase_cnt <= '0;
              puf_reset <= 1'b0;
              state     <= S_ARM;
            end else begin
              phase_cnt <= phase_cnt + 8'd1;
            end
          end

          S_ARM: begin
            if (phase_cnt == 8'd1) begin
              phase_cnt <= '0;
              trigger   <= 1'b1;
              state     <= S_FIRE;
            end else begin
              phase_cnt <= phase_cnt + 8'd1;
            end
          end

          S_FIRE: begin
            if (phase_cnt == SETTLE_LAST) begin
              phase_cnt <= '0;
              state     <= S_SAMPLE;
            end else begin
              phase_cnt <= phase_cnt + 8'd1;
            end
          end

          S_SAMPLE: begin
            // Trigger stays high through this cycle.
            // The PUF response is captured on the edge that leaves it.
            votes     <= votes_nxt;
            eval_cnt  <= eval_cnt + 4'd1;
            trigger   <= 1'b0;
            puf_reset <= 1'b1;
            if ((eval_cnt + 4'd1) < NEV) begin
              state <= S_CLEAR;
            end else begin
              response_out <= maj_nxt;
              unstable     <= unst_nxt;
              done         <= 1'b1;
              state        <= S_DONE;
            end
          end

          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end

          default: begin
            trigger   <= 1'b0;
            puf_reset <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// tb/tb_puf_eval_ctrl.sv - scoreboard testbench for puf_eval_ctrl
module tb_puf_eval_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [127:0] challenge_in = '0;
  logic [15:0]  a_in = '0;
  logic [15:0]  b_in = '0;
  logic [127:0] CHALLENGE;
  logic [15:0]  a;
  logic [15:0]  b;
  logic         trigger;
  logic         puf_reset;
  logic [15:0]  RESPONSE = '0;
  logic         busy;
  logic         done;
  logic [15:0]  response_out;
  logic [15:0]  unstable;

  puf_eval_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .challenge_in (challenge_in),
    .a_in         (a_in),
    .b_in         (b_in),
    .CHALLENGE    (CHALLENGE),
    .a            (a),
    .b            (b),
    .trigger      (trigger),
    .puf_reset    (puf_reset),
    .RESPONSE     (RESPONSE),
    .busy         (busy),
    .done         (done),
    .response_out (response_out),
    .unstable     (unstable)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] resp;
    logic [15:0] unst;
    int          acc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // PUF model: one table entry per evaluation.
  // The entry advances whenever the trigger falls.
  logic [15:0] tab [8];
  int          idx = 0;
  logic        prev_trig = 1'b0;

  always @(negedge clk) begin
    if (!busy) idx = 0;
    else if (prev_trig && !trigger && idx < 7) idx = idx + 1;
    prev_trig = trigger;
    RESPONSE  = tab[idx];
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("response_out", 128'(response_out), 128'(e.resp));
        chk("unstable", 128'(unstable), 128'(e.unst));
        chk("done_latency", 128'(cyc - e.acc), 128'(161));
      end
    end
  end

  task automatic fill_tab(input logic [15:0] v);
    for (int i = 0; i < 8; i++) tab[i] = v;
  endtask

  // Called at a negedge.
  // Returns at the negedge after the accepting edge, which is the first
  // CLEAR cycle.
  task automatic issue(input logic [127:0] ch, input logic [15:0] av, input logic [15:0] bv,
                       input logic [15:0] er, input logic [15:0] eu, input bit push);
    exp_t e;
    start        = 1'b1;
    challenge_in = ch;
    a_in         = av;
    b_in         = bv;
    if (push) begin
      e.resp = er;
      e.unst = eu;
      e.acc  = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (done === 1'b1) seen = 1;
      else @(negedge clk);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done expected=done", name);
    end
  endtask

  initial begin
    logic [127:0] ch0;
    logic [15:0]  a0;
    logic [15:0]  b0;
    int           bad [7];
    int           unstab;

    fill_tab(16'h0000);

    // Held in reset
    repeat (3) @(negedge clk);
    chk("rst_trigger", 128'(trigger), 128'(0));
    chk("rst_puf_reset", 128'(puf_reset), 128'(1));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_challenge", CHALLENGE, 128'(0));
    chk("rst_ab", 128'({a, b}), 128'(0));
    chk("rst_response_out", 128'(response_out), 128'(0));
    chk("rst_unstable", 128'(unstable), 128'(0));
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_puf_reset", 128'(puf_reset), 128'(1));

    // Constant response plus per-cycle waveform
    fill_tab(16'hA5C3);
    @(negedge clk);
    ch0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    a0  = 16'h1234;
    b0  = 16'hBEEF;
    issue(ch0, a0, b0, 16'hA5C3, 16'h0000, 1);
    for (int e = 0; e < 7; e++) bad[e] = 0;
    unstab = 0;
    for (int n = 0; n < 161; n++) begin
      int  c;
      logic ep;
      logic et;
      c  = n % 23;
      ep = (c < 4);
      et = (c >= 6);
      if (puf_reset !== ep || trigger !== et || busy !== 1'b1) bad[n / 23]++;
      if (CHALLENGE !== ch0 || a !== a0 || b !== b0) unstab++;
      @(negedge clk);
    end
    for (int e = 0; e < 7; e++) chk($sformatf("eval%0d_waveform_bad_cycles", e), 128'(bad[e]), 128'(0));
    chk("operands_stable_bad_cycles", 128'(unstab), 128'(0));
    wait_done("t1");
    @(negedge clk);
    chk("t1_back_idle_busy", 128'(busy), 128'(0));

    // Split votes, start while busy, start in the DONE cycle
    tab[0] = 16'hA003;
    tab[1] = 16'hA001;
    tab[2] = 16'hA003;
    tab[3] = 16'hA000;
    tab[4] = 16'hA001;
    tab[5] = 16'hA002;
    tab[6] = 16'hC000;
    tab[7] = 16'h0000;
    @(negedge clk);
    ch0 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    issue(ch0, 16'h5555, 16'hAAAA, 16'hA001, 16'h6003, 1);
    repeat (30) @(negedge clk);
    start        = 1'b1;
    challenge_in = 128'hFFFF;
    a_in         = 16'h0F0F;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("busy_start_ignored_challenge", CHALLENGE, ch0);
    chk("busy_start_ignored_a", 128'(a), 128'(16'h5555));
    wait_done("t2");
    start        = 1'b1;
    challenge_in = 128'h7777;
    @(negedge clk);
    start = 1'b0;
    chk("done_cycle_start_busy", 128'(busy), 128'(0));
    chk("done_cycle_start_challenge", CHALLENGE, ch0);
    repeat (3) @(negedge clk);
    chk("done_cycle_start_still_idle", 128'(busy), 128'(0));

    // Abort mid-measurement
    fill_tab(16'hFFFF);
    @(negedge clk);
    issue(128'h42, 16'h1, 16'h2, 16'h0, 16'h0, 0);
    repeat (50) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_trigger", 128'(trigger), 128'(0));
    chk("abort_puf_reset", 128'(puf_reset), 128'(1));
    repeat (200) @(negedge clk);
    chk("abort_response_kept", 128'(response_out), 128'(16'hA001));
    chk("abort_unstable_kept", 128'(unstable), 128'(16'h6003));

    // Abort while idle does nothing
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", 128'(busy), 128'(0));
    chk("idle_abort_puf_reset", 128'(puf_reset), 128'(1));

    // Asynchronous reset mid-measurement, then a fresh measurement
    issue(128'h99, 16'h3, 16'h4, 16'h0, 16'h0, 0);
    repeat (100) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_busy", 128'(busy), 128'(0));
    chk("async_rst_trigger", 128'(trigger), 128'(0));
    chk("async_rst_puf_reset", 128'(puf_reset), 128'(1));
    chk("async_rst_challenge", CHALLENGE, 128'(0));
    chk("async_rst_response_out", 128'(response_out), 128'(0));
    chk("async_rst_unstable", 128'(unstable), 128'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    fill_tab(16'h3C96);
    repeat (2) @(negedge clk);
    issue(128'hCAFE, 16'h6, 16'h7, 16'h3C96, 16'h0000, 1);
    wait_done("t4");
    repeat (3) @(negedge clk);

    chk("scoreboard_drained", 128'(sb.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/puf_eval_ctrl.md
PUF_EVAL_CTRL -- requirements
Module: puf_eval_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 4, cycles puf_reset is held high per evaluation (legal 1..255).
REQ-002 Parameter SETTLE_CYCLES, default 16, cycles trigger is held high before sampling (legal 1..255).
REQ-003 Parameter N_EVAL, default 7, evaluations per measurement for majority vote (odd only, 1..15).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  measurement request; sampled only in IDLE.
REQ-007 abort  in  1  cancels a measurement in progress.
REQ-008 challenge_in  in  128  challenge for the measurement.
REQ-009 a_in, b_in  in  16 each  operand words producing PUF stimulus edges.
REQ-010 CHALLENGE  out  128  challenge driven to the PUF array.
REQ-011 a, b  out  16 each  operand words driven to the PUF array.
REQ-012 trigger  out  1  PUF launch strobe.
REQ-013 puf_reset  out  1  active-high reset to the PUF arbiters.
REQ-014 RESPONSE  in  16  raw PUF array response.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse when a measurement completes.
REQ-017 response_out  out  16  majority-voted response.
REQ-018 unstable  out  16  per-bit flag: votes for that bit were not unanimous.

Function
REQ-019 States SHALL be IDLE, CLEAR, ARM, FIRE, SAMPLE and DONE, with all outputs registered.
REQ-020 In IDLE with start=1, the block SHALL latch challenge_in/a_in/b_in onto CHALLENGE/a/b, clear all vote counters and eval count, and enter CLEAR.
REQ-021 CHALLENGE, a and b SHALL stay constant from accept until the next accept.
REQ-022 CLEAR SHALL last RST_CYCLES cycles with puf_reset=1 and trigger=0.
REQ-023 ARM SHALL last 2 cycles with puf_reset=0 and trigger=0.
REQ-024 FIRE SHALL last SETTLE_CYCLES cycles with trigger=1.
REQ-025 SAMPLE SHALL last 1 cycle with trigger=1.
REQ-026 In SAMPLE, each vote counter i (4 bits) SHALL increment when RESPONSE[i]=1.
REQ-027 In SAMPLE, the eval count SHALL increment.
REQ-028 After SAMPLE, the block SHALL go to CLEAR if the eval count is below N_EVAL, else to DONE.
REQ-029 Each evaluation SHALL take exactly RST_CYCLES+SETTLE_CYCLES+3 cycles.
REQ-030 done SHALL be high for exactly 1 cycle, N_EVAL*(RST_CYCLES+SETTLE_CYCLES+3) edges after the accepting edge (161 at defaults).
REQ-031 On the edge entering DONE, response_out[i] SHALL become 1 iff counter i > N_EVAL/2 (integer division).
REQ-032 On the same edge, unstable[i] SHALL become 1 iff counter i is neither 0 nor N_EVAL.
REQ-033 response_out and unstable SHALL hold their values until the next DONE.
REQ-034 DONE SHALL return to IDLE after one cycle.
REQ-035 start SHALL be ignored while busy=1.
REQ-036 A start in the cycle DONE is active SHALL be ignored; it is accepted only when sampled in IDLE.
REQ-037 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with trigger=0 and puf_reset=1 for that cycle.
REQ-038 On abort, done SHALL NOT pulse and response_out/unstable SHALL be unchanged.
REQ-039 abort SHALL take priority over every state transition.
REQ-040 abort in IDLE SHALL have no effect.
REQ-041 In IDLE, trigger SHALL be 0 and puf_reset SHALL be 1 (except on the cycle of accept, see REQ-020).

Reset
REQ-042 reset=0 SHALL force IDLE asynchronously.
REQ-043 During reset: trigger=0, puf_reset=1, busy=0, done=0.
REQ-044 During reset: CHALLENGE, a, b, response_out, unstable, the vote counters and the eval count SHALL all be 0.
REQ-045 reset asserted mid-measurement SHALL discard partial votes and SHALL NOT produce done.

Verification
REQ-046 Defaults; RESPONSE held at 16'hA5C3; pulse start -> done exactly 161 edges after accept, response_out=16'hA5C3, unstable=16'h0000.
REQ-047 RESPONSE bit0=1 in 4 of 7 SAMPLE cycles, bit1=1 in 3 of 7 -> response_out[1:0]=2'b01, unstable[1:0]=2'b11.
REQ-048 Check the PUF-side waveform in each evaluation: puf_reset high for 4 cycles, trigger low for 2, trigger high for 17; CHALLENGE/a/b stable throughout.
REQ-049 Assert abort at cycle 50 of a measurement -> IDLE next edge, no done, response_out equals the previous result.
REQ-050 Pulse start while busy -> ignored; done occurs once.
REQ-051 Pulse start in the DONE cycle -> not accepted.
REQ-052 Assert reset at cycle 100 -> all outputs return to reset values immediately; a fresh start gives correct 161-cycle latency.
